imem_arbiter: RTL and testbench
===============================

# imem_arbiter

Two-requester arbiter sharing the single-port instruction memory between the fetch stage and the program loader/debug port. It grants one access per cycle, locks the port for loader bursts, and routes the 1-cycle-latency read data back to the issuing requester. It drives `stall_f` so the PC and fetch pipeline register hold while fetch is not granted.

## Interface
Parameters:
- `AW`, 32, address width (byte address, word aligned)
- `DW`, 32, data width
- `STARVE_LIMIT`, 4, consecutive loader beats before a forced fetch slot (guard build only); range 1..15

Ports:
- `clk`  in  1  single clock, all logic on posedge
- `rst`  in  1  synchronous, active-low reset; sampled on posedge clk only
- `f_req`  in  1  fetch read request
- `f_addr`  in  AW  fetch address (PCF)
- `f_gnt`  out  1  fetch beat accepted this cycle
- `f_valid`  out  1  fetch read data valid (cycle after grant)
- `f_rdata`  out  DW  fetch read data
- `stall_f`  out  1  `f_req & ~f_gnt`; hold PC and fetch register
- `l_req`  in  1  loader request
- `l_we`  in  1  loader write (1) / read (0)
- `l_addr`  in  AW  loader address
- `l_wdata`  in  DW  loader write data
- `l_last`  in  1  final beat of loader burst
- `l_gnt`  out  1  loader beat accepted this cycle
- `l_valid`  out  1  loader read data valid (cycle after read grant)
- `l_rdata`  out  DW  loader read data
- `m_en`, `m_we`  out  1  memory enable / write enable
- `m_addr`  out  AW, `m_wdata`  out  DW  memory address / write data
- `m_rdata`  in  DW  memory read data, valid one cycle after `m_en & ~m_we`

## Operation
- FSM states: IDLE, LOAD (burst locked to loader).
- Grants are combinational from state, requests and `last_win`; at most one of `f_gnt`/`l_gnt` high per cycle.
- IDLE arbitration:
  - only `f_req`: fetch wins.
  - only `l_req`: loader wins.
  - both: round-robin; winner is the requester that did not win last (`last_win` reg, reset = loader, so fetch wins first contest).
- A loader grant with `l_last=0` moves IDLE->LOAD. In LOAD only the loader is granted; fetch stalls. A loader grant with `l_last=1` returns to IDLE next cycle. A single-beat burst (`l_last=1` on first beat) stays in IDLE.
- In LOAD with `l_req=0`: no grant, state held (burst paused, not aborted).
- Memory mux: `m_en = f_gnt | l_gnt`; address/data from the granted side; `m_we = l_gnt & l_we`; fetch never writes.
- Return routing: registered tag `rd_owner`/`rd_pend` set on a read grant. Next cycle, the matching `*_valid` pulses for one cycle with `*_rdata = m_rdata`. Non-pending `*_rdata` = 0. Loader writes produce no valid.
- `last_win` updates on every grant.

## Timing
- Grant latency: 0 cycles (same cycle as request when eligible). Read data latency: 1 cycle after grant.
- Back-to-back grants every cycle are allowed; throughput 1 access/cycle.
- Requester must hold req/addr/data stable until its gnt is seen.
- Reset (rst=0 at posedge): state=IDLE, `last_win`=loader, `rd_pend`=0, starve count=0. With rst low, all grants, `m_en`, `m_we`, `*_valid` are forced 0, `*_rdata` = 0, and `stall_f`=0.
- Reset mid-burst aborts the burst. A pending read valid is dropped. After rst returns high, arbitration restarts from IDLE.

## Configuration
- `IMEM_ARB_STARVE_GUARD_EN` defined:
  - A 4-bit counter counts consecutive loader grants in LOAD and clears on any fetch grant or on IDLE.
  - When count == `STARVE_LIMIT` and `f_req=1`, the next cycle grants fetch instead of the loader. The state stays LOAD and the counter clears.
- Not defined: LOAD is strictly locked and fetch may stall for the full burst.

## Test plan
- Reset: rst=0 for 3 cycles with `f_req=l_req=1` -> all grants/valids 0, `m_en=0`. First cycle after release: `f_gnt=1`.
- Fetch only: `f_req=1`, addrs 0x0,0x4,0x8 on consecutive cycles -> `f_gnt=1` each cycle. `f_valid` follows 1 cycle later with mem words; `stall_f=0`.
- Contention in IDLE: both req every cycle with single-beat loader reads (`l_last=1`) -> grants alternate F,L,F,L. Each valid returns to the correct side.
- Burst lock: loader 4-beat write burst at 0x100..0x10C, `f_req=1` throughout -> 4 `l_gnt`, `stall_f=1` for 4 cycles, `m_we=1`. Fetch granted on the cycle after `l_last`; no `l_valid`.
- Reset mid-burst: rst=0 after beat 2 of a 4-beat read burst -> no valid for beat 2. After release, state IDLE, and a new `f_req` is granted immediately.
- Guard build, `STARVE_LIMIT=4`: 10-beat loader burst with `f_req=1` -> grant pattern LLLLF LLLLF L… Fetch valid is correct; the burst completes.

Source files
------------

// File: rtl/imem_arbiter.sv
// Fetch / loader arbiter for the single-port instruction memory, with burst lock and 1-cycle read return routing.
// Optional fetch starvation guard during loader bursts: define IMEM_ARB_STARVE_GUARD_EN.
module imem_arbiter #(
    parameter int AW           = 32,
    parameter int DW           = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          f_req,
    input  logic [AW-1:0] f_addr,
    output logic          f_gnt,
    output logic          f_valid,
    output logic [DW-1:0] f_rdata,
    output logic          stall_f,
    input  logic          l_req,
    input  logic          l_we,
    input  logic [AW-1:0] l_addr,
    input  logic [DW-1:0] l_wdata,
    input  logic          l_last,
    output logic          l_gnt,
    output logic          l_valid,
    output logic [DW-1:0] l_rdata,
    output logic          m_en,
    output logic          m_we,
    output logic [AW-1:0] m_addr,
    output logic [DW-1:0] m_wdata,
    input  logic [DW-1:0] m_rdata
);

    // state | meaning
    // IDLE  | round-robin between fetch and loader, one beat per cycle
    // LOAD  | loader burst in progress, port locked to the loader
    typedef enum logic {
        IDLE = 1'b0,
        LOAD = 1'b1
    } state_t;

    state_t state, state_next;
    logic   last_win, last_win_next;   // 1 = loader won the most recent grant
    logic   rd_pend, rd_owner;         // rd_owner 1 = loader read in flight
    logic   force_fetch;

    if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_limit_check
        $error("imem_arbiter: STARVE_LIMIT must be in 1..15");
    end

`ifdef IMEM_ARB_STARVE_GUARD_EN
    logic [3:0] starve_cnt, starve_cnt_next;

    assign force_fetch = (state == LOAD) && (starve_cnt == 4'(STARVE_LIMIT)) && f_req;

    // The beat that opens a burst from IDLE counts toward the limit.
    always_comb begin
        starve_cnt_next = starve_cnt;
        if (f_gnt || (state == IDLE && !(l_gnt && !l_last))) begin
            starve_cnt_next = 4'd0;
        end else if (l_gnt && starve_cnt != 4'hF) begin
            starve_cnt_next = starve_cnt + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            starve_cnt <= 4'd0;
        end else begin
            starve_cnt <= starve_cnt_next;
        end
    end
`else
    assign force_fetch = 1'b0;
`endif

    always_comb begin
        state_next = state;
        f_gnt      = 1'b0;
        l_gnt      = 1'b0;
        if (rst) begin
            case (state)
                IDLE: begin
                    if (f_req && l_req) begin
                        f_gnt = last_win;
                        l_gnt = !last_win;
                    end else begin
                        f_gnt = f_req;
                        l_gnt = l_req;
                    end
                    if (l_gnt && !l_last) begin
                        state_next = LOAD;
                    end
                end
                LOAD: begin
                    if (force_fetch) begin
                        f_gnt = 1'b1;
                    end else begin
                        l_gnt = l_req;
                        if (l_req && l_last) begin
                            state_next = IDLE;
                        end
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_comb begin
        last_win_next = last_win;
        if (f_gnt) begin
            last_win_next = 1'b0;
        end else if (l_gnt) begin
            last_win_next = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= IDLE;
            last_win <= 1'b1;
            rd_pend  <= 1'b0;
            rd_owner <= 1'b0;
        end else begin
            state    <= state_next;
            last_win <= last_win_next;
            rd_pend  <= f_gnt || (l_gnt && !l_we);
            rd_owner <= l_gnt;
        end
    end

    assign m_en    = f_gnt | l_gnt;
    assign m_we    = l_gnt & l_we;
    assign m_addr  = l_gnt ? l_addr : f_addr;
    assign m_wdata = l_gnt ? l_wdata : '0;

    assign stall_f = rst & f_req & ~f_gnt;

    // Valids are masked by rst so a read granted just before reset is dropped.
    assign f_valid = rst & rd_pend & ~rd_owner;
    assign l_valid = rst & rd_pend & rd_owner;
    assign f_rdata = f_valid ? m_rdata : '0;
    assign l_rdata = l_valid ? m_rdata : '0;

endmodule

// File: tb/tb_imem_arbiter.sv
// Directed bench for imem_arbiter with a 1-cycle-latency memory model.
// Long-burst expectations switch with IMEM_ARB_STARVE_GUARD_EN.
module tb_imem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        f_req, l_req, l_we, l_last;
    logic [31:0] f_addr, l_addr, l_wdata;
    logic        f_gnt, f_valid, stall_f, l_gnt, l_valid, m_en, m_we;
    logic [31:0] f_rdata, l_rdata, m_addr, m_wdata;
    logic [31:0] m_rdata;

    int checks = 0;
    int errors = 0;

    logic [31:0] mem [0:255];

    always #5 clk = ~clk;

    imem_arbiter #(.AW(32), .DW(32), .STARVE_LIMIT(4)) dut (
        .clk(clk), .rst(rst),
        .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_valid(f_valid),
        .f_rdata(f_rdata), .stall_f(stall_f),
        .l_req(l_req), .l_we(l_we), .l_addr(l_addr), .l_wdata(l_wdata),
        .l_last(l_last), .l_gnt(l_gnt), .l_valid(l_valid), .l_rdata(l_rdata),
        .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_rdata(m_rdata)
    );

    always @(posedge clk) begin
        if (m_en && !m_we) m_rdata <= mem[m_addr[9:2]];
        if (m_en && m_we)  mem[m_addr[9:2]] <= m_wdata;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0; f_req = 1'b1; l_req = 1'b1; l_we = 1'b0; l_last = 1'b1;
        f_addr = 32'h0; l_addr = 32'h10; l_wdata = 32'h0;
        for (int i = 0; i < 3; i++) begin
            tick(); #1;
            checks++;
            if ({f_gnt, l_gnt, m_en, m_we, f_valid, l_valid, stall_f} !== 7'b0 ||
                f_rdata !== 32'h0 || l_rdata !== 32'h0) begin
                errors++;
                $display("FAIL reset_outputs cyc%0d: f_gnt=%b l_gnt=%b m_en=%b m_we=%b f_valid=%b l_valid=%b stall_f=%b f_rdata=%h l_rdata=%h, expected all 0",
                         i, f_gnt, l_gnt, m_en, m_we, f_valid, l_valid, stall_f, f_rdata, l_rdata);
            end
        end
        tick(); rst = 1'b1; #1;
        checks++;
        if (f_gnt !== 1'b1 || l_gnt !== 1'b0) begin
            errors++;
            $display("FAIL reset_release_grant: f_gnt=%b l_gnt=%b, expected 1 0", f_gnt, l_gnt);
        end
        tick(); f_req = 1'b0; l_req = 1'b0; #1;
        checks++;
        if (f_valid !== 1'b1 || f_rdata !== 32'hA000_0000 || l_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_release_data: f_valid=%b f_rdata=%h l_valid=%b, expected 1 a0000000 0",
                     f_valid, f_rdata, l_valid);
        end
    endtask

    task automatic test_fetch_only();
        for (int i = 0; i < 4; i++) begin
            tick();
            l_req = 1'b0;
            f_req = (i < 3);
            f_addr = 32'(4 * i);
            #1;
            if (i < 3) begin
                checks++;
                if (f_gnt !== 1'b1 || stall_f !== 1'b0 || m_addr !== 32'(4 * i) || m_we !== 1'b0 || m_en !== 1'b1) begin
                    errors++;
                    $display("FAIL fetch_grant cyc%0d: f_gnt=%b stall_f=%b m_en=%b m_we=%b m_addr=%h, expected 1 0 1 0 %h",
                             i, f_gnt, stall_f, m_en, m_we, m_addr, 32'(4 * i));
                end
            end
            if (i > 0) begin
                checks++;
                if (f_valid !== 1'b1 || f_rdata !== 32'hA000_0000 + 32'(i - 1)) begin
                    errors++;
                    $display("FAIL fetch_data cyc%0d: f_valid=%b f_rdata=%h, expected 1 %h",
                             i, f_valid, f_rdata, 32'hA000_0000 + 32'(i - 1));
                end
            end
        end
    endtask

    task automatic test_loader_single();
        tick();
        f_req = 1'b0; l_req = 1'b1; l_we = 1'b0; l_last = 1'b1; l_addr = 32'h20;
        #1;
        checks++;
        if (l_gnt !== 1'b1 || f_gnt !== 1'b0 || m_addr !== 32'h20 || m_we !== 1'b0) begin
            errors++;
            $display("FAIL loader_grant: l_gnt=%b f_gnt=%b m_addr=%h m_we=%b, expected 1 0 00000020 0",
                     l_gnt, f_gnt, m_addr, m_we);
        end
        tick(); l_req = 1'b0; #1;
        checks++;
        if (l_valid !== 1'b1 || l_rdata !== 32'hA000_0008 || f_valid !== 1'b0 || f_rdata !== 32'h0) begin
            errors++;
            $display("FAIL loader_data: l_valid=%b l_rdata=%h f_valid=%b f_rdata=%h, expected 1 a0000008 0 0",
                     l_valid, l_rdata, f_valid, f_rdata);
        end
    endtask

    task automatic test_contention();
        logic [31:0] fa, la, pdata;
        logic        exp_f, pf;
        int          fk, lk;
        fa = 32'h40; la = 32'h80; fk = 0; lk = 0; pf = 1'b0; pdata = 32'h0;
        for (int c = 0; c < 5; c++) begin
            tick();
            f_req = (c < 4); l_req = (c < 4); l_we = 1'b0; l_last = 1'b1;
            f_addr = fa; l_addr = la;
            #1;
            exp_f = (c % 2 == 0);
            if (c < 4) begin
                checks++;
                if (f_gnt !== exp_f || l_gnt !== !exp_f || stall_f !== !exp_f || m_addr !== (exp_f ? fa : la)) begin
                    errors++;
                    $display("FAIL contention_grant cyc%0d: f_gnt=%b l_gnt=%b stall_f=%b m_addr=%h, expected %b %b %b %h",
                             c, f_gnt, l_gnt, stall_f, m_addr, exp_f, !exp_f, !exp_f, exp_f ? fa : la);
                end
            end
            if (c > 0) begin
                checks++;
                if (f_valid !== pf || l_valid !== !pf ||
                    f_rdata !== (pf ? pdata : 32'h0) || l_rdata !== (pf ? 32'h0 : pdata)) begin
                    errors++;
                    $display("FAIL contention_data cyc%0d: f_valid=%b f_rdata=%h l_valid=%b l_rdata=%h, expected owner=%s data=%h",
                             c, f_valid, f_rdata, l_valid, l_rdata, pf ? "fetch" : "loader", pdata);
                end
            end
            if (c < 4) begin
                pf = exp_f;
                if (exp_f) begin
                    pdata = 32'hA000_0010 + 32'(fk); fk++; fa += 32'h4;
                end else begin
                    pdata = 32'hA000_0020 + 32'(lk); lk++; la += 32'h4;
                end
            end
        end
    endtask

    task automatic test_burst_lock();
        tick();
        f_req = 1'b1; f_addr = 32'h200;
        l_req = 1'b1; l_we = 1'b1; l_addr = 32'h100; l_wdata = 32'hD000_0000; l_last = 1'b0;
        #1;
        checks++;
        if (f_gnt !== 1'b1 || l_gnt !== 1'b0) begin
            errors++;
            $display("FAIL burst_pre_fetch: f_gnt=%b l_gnt=%b, expected 1 0", f_gnt, l_gnt);
        end
        for (int b = 0; b < 4; b++) begin
            tick();
            f_addr = 32'h204;
            l_addr = 32'h100 + 32'(4 * b);
            l_wdata = 32'hD000_0000 + 32'(b);
            l_last = (b == 3);
            #1;
            checks++;
            if (l_gnt !== 1'b1 || f_gnt !== 1'b0 || stall_f !== 1'b1 || m_we !== 1'b1 ||
                m_addr !== 32'h100 + 32'(4 * b) || m_wdata !== 32'hD000_0000 + 32'(b) || l_valid !== 1'b0) begin
                errors++;
                $display("FAIL burst_beat%0d: l_gnt=%b f_gnt=%b stall_f=%b m_we=%b m_addr=%h m_wdata=%h l_valid=%b, expected 1 0 1 1 %h %h 0",
                         b, l_gnt, f_gnt, stall_f, m_we, m_addr, m_wdata, l_valid,
                         32'h100 + 32'(4 * b), 32'hD000_0000 + 32'(b));
            end
            if (b == 0) begin
                checks++;
                if (f_valid !== 1'b1 || f_rdata !== 32'hA000_0080) begin
                    errors++;
                    $display("FAIL burst_pre_fetch_data: f_valid=%b f_rdata=%h, expected 1 a0000080", f_valid, f_rdata);
                end
            end
        end
        tick(); l_req = 1'b0; l_we = 1'b0; l_last = 1'b0; #1;
        checks++;
        if (f_gnt !== 1'b1 || stall_f !== 1'b0 || m_addr !== 32'h204 || l_valid !== 1'b0) begin
            errors++;
            $display("FAIL burst_release: f_gnt=%b stall_f=%b m_addr=%h l_valid=%b, expected 1 0 00000204 0",
                     f_gnt, stall_f, m_addr, l_valid);
        end
        tick(); f_addr = 32'h104; #1;
        checks++;
        if (f_gnt !== 1'b1 || f_valid !== 1'b1 || f_rdata !== 32'hA000_0081 || l_valid !== 1'b0) begin
            errors++;
            $display("FAIL burst_after_data: f_gnt=%b f_valid=%b f_rdata=%h l_valid=%b, expected 1 1 a0000081 0",
                     f_gnt, f_valid, f_rdata, l_valid);
        end
        tick(); f_req = 1'b0; #1;
        checks++;
        if (f_valid !== 1'b1 || f_rdata !== 32'hD000_0001) begin
            errors++;
            $display("FAIL burst_written_word: f_valid=%b f_rdata=%h, expected 1 d0000001", f_valid, f_rdata);
        end
    endtask

    task automatic test_reset_mid_burst();
        for (int b = 0; b < 3; b++) begin
            tick();
            f_req = 1'b0; l_req = 1'b1; l_we = 1'b0; l_last = 1'b0;
            l_addr = 32'h300 + 32'(4 * b);
            #1;
            checks++;
            if (l_gnt !== 1'b1 || (b > 0 && (l_valid !== 1'b1 || l_rdata !== 32'hA000_00C0 + 32'(b - 1)))) begin
                errors++;
                $display("FAIL midburst_beat%0d: l_gnt=%b l_valid=%b l_rdata=%h, expected 1 %b %h",
                         b, l_gnt, l_valid, l_rdata, b > 0, 32'hA000_00C0 + 32'(b - 1));
            end
        end
        tick(); rst = 1'b0; l_addr = 32'h30C; #1;
        checks++;
        if (l_valid !== 1'b0 || l_rdata !== 32'h0 || l_gnt !== 1'b0 || m_en !== 1'b0) begin
            errors++;
            $display("FAIL midburst_drop: l_valid=%b l_rdata=%h l_gnt=%b m_en=%b, expected 0 0 0 0",
                     l_valid, l_rdata, l_gnt, m_en);
        end
        tick(); rst = 1'b1; f_req = 1'b1; f_addr = 32'h10; #1;
        checks++;
        if (f_gnt !== 1'b1 || l_gnt !== 1'b0 || stall_f !== 1'b0) begin
            errors++;
            $display("FAIL midburst_restart: f_gnt=%b l_gnt=%b stall_f=%b, expected 1 0 0", f_gnt, l_gnt, stall_f);
        end
        tick(); f_req = 1'b0; l_req = 1'b0; #1;
        checks++;
        if (f_valid !== 1'b1 || f_rdata !== 32'hA000_0004 || l_valid !== 1'b0) begin
            errors++;
            $display("FAIL midburst_restart_data: f_valid=%b f_rdata=%h l_valid=%b, expected 1 a0000004 0",
                     f_valid, f_rdata, l_valid);
        end
    endtask

    task automatic test_long_burst();
        string       pat;
        int          b, k;
        logic        exp_f, has_prev, pf;
        logic [31:0] pdata;
`ifdef IMEM_ARB_STARVE_GUARD_EN
        pat = "LLLLFLLLLFLLF";
`else
        pat = "LLLLLLLLLLF";
`endif
        b = 0; k = 0; has_prev = 1'b0; pf = 1'b0; pdata = 32'h0;
        for (int c = 0; c <= pat.len(); c++) begin
            tick();
            f_req = (c < pat.len());
            f_addr = 32'h1C0 + 32'(4 * k);
            l_req = (c < pat.len()) && (b < 10);
            l_we = 1'b0;
            l_addr = 32'h180 + 32'(4 * b);
            l_last = (b == 9);
            #1;
            exp_f = 1'b0;
            if (c < pat.len()) begin
                exp_f = (pat[c] == "F");
                checks++;
                if (f_gnt !== exp_f || l_gnt !== !exp_f || stall_f !== !exp_f) begin
                    errors++;
                    $display("FAIL long_burst_grant cyc%0d: f_gnt=%b l_gnt=%b stall_f=%b, expected %b %b %b",
                             c, f_gnt, l_gnt, stall_f, exp_f, !exp_f, !exp_f);
                end
            end
            if (has_prev) begin
                checks++;
                if (f_valid !== pf || l_valid !== !pf ||
                    f_rdata !== (pf ? pdata : 32'h0) || l_rdata !== (pf ? 32'h0 : pdata)) begin
                    errors++;
                    $display("FAIL long_burst_data cyc%0d: f_valid=%b f_rdata=%h l_valid=%b l_rdata=%h, expected owner=%s data=%h",
                             c, f_valid, f_rdata, l_valid, l_rdata, pf ? "fetch" : "loader", pdata);
                end
            end
            if (c < pat.len()) begin
                has_prev = 1'b1;
                pf = exp_f;
                if (exp_f) begin
                    pdata = 32'hA000_0070 + 32'(k); k++;
                end else begin
                    pdata = 32'hA000_0060 + 32'(b); b++;
                end
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'hA000_0000 + 32'(i);
        test_reset();
        test_fetch_only();
        test_loader_single();
        test_contention();
        test_burst_lock();
        test_reset_mid_burst();
        test_long_burst();
        tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
